// File: rtl/cp_remover.sv
// cp_remover
//   Cyclic-prefix removal and symbol framing. Takes the time-aligned sample
//   stream from the timing synchronizer. The first accepted sample is the
//   first CP sample of the first symbol. For every OFDM symbol the block
//   drops the NCP prefix samples and forwards the NFFT useful samples to the
//   FFT over a Wishbone-style streaming handshake. It flags the first useful
//   sample of each symbol and counts completed symbols per frame.
//
// Ports
//   CLK_I, RST_I            clock, synchronous active-high reset
//   DAT_I/CYC_I/STB_I/ACK_O upstream slave side   ([31:16] imag, [15:0] real)
//   DAT_O/CYC_O/STB_O/WE_O  downstream master side
//   ACK_I                   downstream accept
//   SOS_O                   start of symbol, qualified by STB_O
//   SYM_CNT                 completed symbols in the current frame (saturating)
//   ABORT_O                 one-cycle pulse when the frame ends mid-symbol
module cp_remover #(
  parameter int NFFT = 256,
  parameter int NCP  = 64,
  parameter int CW   = 9,
  parameter int SW   = 8
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [31:0]   DAT_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  output logic          ACK_O,
  output logic [31:0]   DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I,
  output logic          SOS_O,
  output logic [SW-1:0] SYM_CNT,
  output logic          ABORT_O
);

  typedef enum logic [1:0] {IDLE, CP, DATA, DRAIN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [SW-1:0] sym_nx;
  logic          abort_nx;
  logic          load;
  logic          out_xfer;

  assign WE_O     = STB_O;
  assign out_xfer = STB_O & ACK_I;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sym_nx   = SYM_CNT;
    abort_nx = 1'b0;
    ACK_O    = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (CYC_I) state_nx = CP;
      end
      CP: begin
        if (!CYC_I) begin
          // A drop on a symbol boundary (CP count 0) is a clean frame end.
          state_nx = DRAIN;
          abort_nx = (cnt != '0);
          cnt_nx   = '0;
        end else begin
          // Prefix samples are always taken and thrown away.
          ACK_O = STB_I;
          if (STB_I) begin
            if (cnt == CW'(NCP - 1)) begin
              state_nx = DATA;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
      end
      DATA: begin
        if (!CYC_I) begin
          state_nx = DRAIN;
          abort_nx = 1'b1;
          cnt_nx   = '0;
        end else begin
          // Accept when the output slot is free or is being emptied this cycle.
          ACK_O = STB_I & (~STB_O | ACK_I);
          if (ACK_O) begin
            load = 1'b1;
            if (cnt == CW'(NFFT - 1)) begin
              state_nx = CP;
              cnt_nx   = '0;
              if (SYM_CNT != '1) sym_nx = SYM_CNT + 1'b1;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (!STB_O) begin
          state_nx = IDLE;
          sym_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state   <= IDLE;
      cnt     <= '0;
      SYM_CNT <= '0;
      ABORT_O <= 1'b0;
      DAT_O   <= '0;
      STB_O   <= 1'b0;
      SOS_O   <= 1'b0;
      CYC_O   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      SYM_CNT <= sym_nx;
      ABORT_O <= abort_nx;
      if (load) begin
        // Load wins over drain, so back-to-back transfers leave no bubble.
        DAT_O <= DAT_I;
        STB_O <= 1'b1;
        SOS_O <= (cnt == '0);
        CYC_O <= 1'b1;
      end else if (out_xfer) begin
        STB_O <= 1'b0;
        SOS_O <= 1'b0;
      end
      if (state == DRAIN && !STB_O) CYC_O <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cp_remover.sv
module tb_cp_remover;

  localparam int NFFT = 256;
  localparam int NCP  = 64;
  localparam int SYML = NFFT + NCP;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [31:0] DAT_I = '0;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I = 1'b0;
  logic        SOS_O;
  logic [7:0]  SYM_CNT;
  logic        ABORT_O;

  cp_remover #(.NFFT(NFFT), .NCP(NCP), .CW(9), .SW(8)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I),
    .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ACK_I(ACK_I), .SOS_O(SOS_O), .SYM_CNT(SYM_CNT), .ABORT_O(ABORT_O)
  );

  always #5 CLK_I = ~CLK_I;

  int n_chk = 0;
  int n_fail = 0;

  // Capture of one drive() run.
  logic [31:0] oq_dat[$];
  bit          oq_sos[$];
  int          oq_sym[$];
  int          oq_cyc[$];
  int          in_cyc[0:1023];
  int          abort_cnt, last_sym, viol, timeout;

  function automatic logic [31:0] smp(input int i);
    return {16'(i) ^ 16'hA5A5, 16'(i)};
  endfunction

  // Streams sample indices 0..n-1 with CYC_I high, then drops CYC_I and lets
  // the block drain back to idle. Records every output transfer.
  task automatic drive(input int n, input bit rnd_ack, input bit tog_stb);
    int acc, cyc, post;
    bit done, hold;
    logic [31:0] hold_dat;
    oq_dat.delete(); oq_sos.delete(); oq_sym.delete(); oq_cyc.delete();
    abort_cnt = 0; last_sym = 0; viol = 0; timeout = 0;
    acc = 0; cyc = 0; post = 0; done = 0; hold = 0; hold_dat = '0;
    while (!done) begin
      @(negedge CLK_I);
      if (acc < n) begin
        CYC_I = 1'b1;
        STB_I = tog_stb ? cyc[0] : 1'b1;
        DAT_I = smp(acc);
      end else begin
        CYC_I = 1'b0; STB_I = 1'b0; DAT_I = '0;
        post++;
      end
      ACK_I = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (ABORT_O) abort_cnt++;
      if (CYC_O) last_sym = int'(SYM_CNT);
      if (WE_O !== STB_O) viol++;
      if (hold && DAT_O !== hold_dat) viol++;
      if (STB_O && !ACK_I && ACK_O && CYC_I && (acc % SYML) >= NCP) viol++;
      hold = STB_O && !ACK_I;
      hold_dat = DAT_O;
      if (STB_O && ACK_I) begin
        oq_dat.push_back(DAT_O); oq_sos.push_back(SOS_O);
        oq_sym.push_back(int'(SYM_CNT)); oq_cyc.push_back(cyc);
      end
      if (CYC_I && STB_I && ACK_O) begin
        in_cyc[acc] = cyc;
        acc++;
      end
      cyc++;
      if (post >= 3 && !CYC_O && !STB_O) done = 1;
      if (cyc > 20000) begin timeout = 1; done = 1; end
    end
    ACK_I = 1'b0;
  endtask

  // Compares the captured output stream against the samples 0..n-1 with
  // prefixes removed.
  task automatic check_stream(input string tag, input int n);
    int exp_q[$];
    for (int k = 0; k < n; k++) if ((k % SYML) >= NCP) exp_q.push_back(k);
    n_chk++;
    if (timeout != 0) begin
      n_fail++; $display("FAIL %s timeout: drain did not complete", tag);
    end
    n_chk++;
    if (oq_dat.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d outputs, expected %0d", tag, oq_dat.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++;
        if (oq_dat[i] !== smp(exp_q[i]) ||
            oq_sos[i] !== ((exp_q[i] % SYML) == NCP)) begin
          n_fail++;
          $display("FAIL %s data[%0d]: got %h sos %0b, expected %h sos %0b", tag, i,
                   oq_dat[i], oq_sos[i], smp(exp_q[i]), (exp_q[i] % SYML) == NCP);
          break;
        end
      end
    end
    n_chk++;
    if (viol !== 0) begin
      n_fail++; $display("FAIL %s handshake: %0d violations, expected 0", tag, viol);
    end
    n_chk++;
    if (SYM_CNT !== 8'd0) begin
      n_fail++; $display("FAIL %s idle_sym: got %0d, expected 0", tag, SYM_CNT);
    end
  endtask

  task automatic test_reset();
    RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    #1;
    n_chk++; if (ACK_O !== 1'b0)   begin n_fail++; $display("FAIL rst ACK_O: got %b, expected 0", ACK_O); end
    n_chk++; if (STB_O !== 1'b0)   begin n_fail++; $display("FAIL rst STB_O: got %b, expected 0", STB_O); end
    n_chk++; if (WE_O !== 1'b0)    begin n_fail++; $display("FAIL rst WE_O: got %b, expected 0", WE_O); end
    n_chk++; if (CYC_O !== 1'b0)   begin n_fail++; $display("FAIL rst CYC_O: got %b, expected 0", CYC_O); end
    n_chk++; if (SOS_O !== 1'b0)   begin n_fail++; $display("FAIL rst SOS_O: got %b, expected 0", SOS_O); end
    n_chk++; if (ABORT_O !== 1'b0) begin n_fail++; $display("FAIL rst ABORT_O: got %b, expected 0", ABORT_O); end
    n_chk++; if (SYM_CNT !== 8'd0) begin n_fail++; $display("FAIL rst SYM_CNT: got %0d, expected 0", SYM_CNT); end
    n_chk++; if (DAT_O !== 32'd0)  begin n_fail++; $display("FAIL rst DAT_O: got %h, expected 0", DAT_O); end
    @(negedge CLK_I);
    RST_I = 1'b0;
    @(negedge CLK_I);
  endtask

  task automatic test_steady();
    drive(2 * SYML, 1'b0, 1'b0);
    check_stream("steady", 2 * SYML);
    if (oq_dat.size() == 2 * NFFT) begin
      for (int i = 0; i < 2 * NFFT; i++) begin
        n_chk++;
        if (oq_cyc[i] - in_cyc[(i / NFFT) * SYML + NCP + (i % NFFT)] !== 1) begin
          n_fail++;
          $display("FAIL steady latency[%0d]: got %0d, expected 1", i,
                   oq_cyc[i] - in_cyc[(i / NFFT) * SYML + NCP + (i % NFFT)]);
          break;
        end
      end
      n_chk++;
      if (oq_cyc[NFFT] - oq_cyc[NFFT-1] !== NCP + 1) begin
        n_fail++; $display("FAIL steady cp_gap: got %0d, expected %0d", oq_cyc[NFFT] - oq_cyc[NFFT-1], NCP + 1);
      end
      n_chk++; if (oq_sym[0] !== 0) begin n_fail++; $display("FAIL steady sym_first: got %0d, expected 0", oq_sym[0]); end
      n_chk++; if (oq_sym[NFFT-1] !== 1) begin n_fail++; $display("FAIL steady sym_319: got %0d, expected 1", oq_sym[NFFT-1]); end
      n_chk++; if (oq_sym[NFFT] !== 1) begin n_fail++; $display("FAIL steady sym_384: got %0d, expected 1", oq_sym[NFFT]); end
      n_chk++; if (oq_sym[2*NFFT-1] !== 2) begin n_fail++; $display("FAIL steady sym_639: got %0d, expected 2", oq_sym[2*NFFT-1]); end
    end
    n_chk++; if (abort_cnt !== 0) begin n_fail++; $display("FAIL steady abort: got %0d pulses, expected 0", abort_cnt); end
    n_chk++; if (last_sym !== 2) begin n_fail++; $display("FAIL steady last_sym: got %0d, expected 2", last_sym); end
  endtask

  task automatic test_rand_ack();
    drive(2 * SYML, 1'b1, 1'b0);
    check_stream("rand_ack", 2 * SYML);
    n_chk++; if (last_sym !== 2) begin n_fail++; $display("FAIL rand_ack last_sym: got %0d, expected 2", last_sym); end
  endtask

  task automatic test_stb_toggle();
    drive(2 * SYML, 1'b0, 1'b1);
    check_stream("stb_tog", 2 * SYML);
    n_chk++; if (last_sym !== 2) begin n_fail++; $display("FAIL stb_tog last_sym: got %0d, expected 2", last_sym); end
  endtask

  task automatic test_abort();
    drive(100, 1'b0, 1'b0);
    check_stream("abort", 100);
    n_chk++; if (abort_cnt !== 1) begin n_fail++; $display("FAIL abort pulses: got %0d, expected 1", abort_cnt); end
    n_chk++; if (last_sym !== 0) begin n_fail++; $display("FAIL abort last_sym: got %0d, expected 0", last_sym); end
  endtask

  task automatic test_clean_end();
    drive(SYML, 1'b0, 1'b0);
    check_stream("clean_end", SYML);
    n_chk++; if (abort_cnt !== 0) begin n_fail++; $display("FAIL clean_end abort: got %0d pulses, expected 0", abort_cnt); end
    n_chk++; if (last_sym !== 1) begin n_fail++; $display("FAIL clean_end last_sym: got %0d, expected 1", last_sym); end
  endtask

  task automatic test_mid_reset();
    int k;
    bit seen;
    k = 0; seen = 0;
    CYC_I = 1'b1; STB_I = 1'b1; ACK_I = 1'b0;
    while (!seen && k < 200) begin
      @(negedge CLK_I);
      DAT_I = smp(k);
      #1;
      if (STB_O) seen = 1;
      k++;
    end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL mid_rst setup: STB_O never rose, expected 1"); end
    RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0;
    @(negedge CLK_I);
    #1;
    n_chk++;
    if ({ACK_O, STB_O, WE_O, CYC_O, SOS_O, ABORT_O} !== 6'b0 || SYM_CNT !== 8'd0 || DAT_O !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_rst outputs: got ack%b stb%b we%b cyc%b sos%b abort%b sym%0d dat%h, expected all 0",
               ACK_O, STB_O, WE_O, CYC_O, SOS_O, ABORT_O, SYM_CNT, DAT_O);
    end
    RST_I = 1'b0;
    @(negedge CLK_I);
    drive(SYML, 1'b0, 1'b0);
    check_stream("mid_rst_restart", SYML);
  endtask

  initial begin
    test_reset();
    test_steady();
    test_rand_ack();
    test_stb_toggle();
    test_abort();
    test_clean_end();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
